// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES key schedule.
package aes_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Round count for a key of nk 32-bit words.
  function automatic int unsigned nr_of(input int unsigned nk);
    return nk + 6;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// Combinational next schedule word: w[i] from w[i-NK], w[i-1], phase (i mod NK) and rcon.
module aes_key_word_gen
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4
) (
  input  logic [31:0] i_w_nk,
  input  logic [31:0] i_w_prev,
  input  logic [2:0]  i_phase,
  input  logic [7:0]  i_rcon,
  output logic [31:0] o_w
);

  logic [31:0] w_sbox_in;
  logic [31:0] w_sbox_out;
  logic [31:0] w_temp;

  // Single S-box: the rotated and unrotated SubWord cases never occur in the same cycle.
  aes_sbox u_sbox (
    .i_word (w_sbox_in),
    .o_word (w_sbox_out)
  );

  // Select the S-box input and form temp for the current phase.
  always_comb begin
    w_sbox_in = i_w_prev;
    w_temp    = i_w_prev;
    if (i_phase == 3'd0) begin
      w_sbox_in = {i_w_prev[23:0], i_w_prev[31:24]};
      w_temp    = w_sbox_out ^ {i_rcon, 24'h0};
    end else if (NK == 8 && i_phase == 3'd4) begin
      w_temp = w_sbox_out;
    end
    o_w = i_w_nk ^ w_temp;
  end

endmodule

// File: rtl/aes_sbox.sv
// 32-bit AES S-box: four byte substitutions computed as GF(2^8) inverse plus affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0), then the fixed affine transform.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte-wise substitution of the whole word.
  always_comb begin
    o_word = {sbox_byte(i_word[31:24]), sbox_byte(i_word[23:16]),
              sbox_byte(i_word[15:8]), sbox_byte(i_word[7:0])};
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES key expander: one schedule word per clock into a random-access word file.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [32*NK-1:0] key_in,
  output logic            busy,
  output logic            done,
  input  logic [3:0]      rk_idx,
  output logic [127:0]    rk_out,
  output logic            rk_valid
);

  localparam int unsigned NR    = nr_of(NK);
  localparam int unsigned TOTAL = 4 * (NR + 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
    $error("aes_key_schedule: NK must be 4, 6 or 8");
  end

  state_e      r_state;
  state_e      w_state_next;
  logic [6:0]  r_cnt;
  logic [2:0]  r_phase;
  logic [7:0]  r_rcon;
  logic [31:0] r_win [NK];
  logic [31:0] r_file [TOTAL];
  logic [31:0] w_new;
  logic        w_load;
  logic        w_step;
  logic [6:0]  w_last_word;

  assign w_load = (r_state == StIdle) && start;
  assign w_step = (r_state == StExpand);

  // r_win[0] is w[i-NK], r_win[NK-1] is w[i-1].
  aes_key_word_gen #(
    .NK (NK)
  ) u_word_gen (
    .i_w_nk   (r_win[0]),
    .i_w_prev (r_win[NK-1]),
    .i_phase  (r_phase),
    .i_rcon   (r_rcon),
    .o_w      (w_new)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle:   if (start) w_state_next = StExpand;
      StExpand: begin
        busy = 1'b1;
        if (r_cnt == 7'(TOTAL - 1)) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default:  w_state_next = StIdle;
    endcase
  end

  // Word counter, i mod NK phase and round constant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= '0;
      r_rcon  <= RCON_INIT;
    end else if (w_load) begin
      r_cnt   <= 7'(NK);
      r_phase <= '0;
      r_rcon  <= RCON_INIT;
    end else if (w_step) begin
      r_cnt   <= r_cnt + 7'd1;
      r_phase <= (r_phase == 3'(NK - 1)) ? 3'd0 : r_phase + 3'd1;
      if (r_phase == 3'd0) r_rcon <= xtime(r_rcon);
    end
  end

  // Sliding window of the last NK words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
    end else if (w_load) begin
      for (int j = 0; j < NK; j++) r_win[j] <= key_in[32*(NK-j)-1 -: 32];
    end else if (w_step) begin
      for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
      r_win[NK-1] <= w_new;
    end
  end

  // Word file: key words in parallel on load, then one word per expand cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TOTAL; k++) r_file[k] <= '0;
    end else if (w_load) begin
      for (int k = 0; k < NK; k++) r_file[k] <= key_in[32*(NK-k)-1 -: 32];
    end else if (w_step) begin
      for (int k = 0; k < TOTAL; k++) begin
        if (r_cnt == 7'(k)) r_file[k] <= w_new;
      end
    end
  end

  assign w_last_word = {1'b0, rk_idx, 2'b11};
  assign rk_valid    = (32'(rk_idx) <= NR) && (w_last_word < r_cnt);

  // Round-key read port; indices past NR match no word and read as zero.
  always_comb begin
    rk_out = '0;
    for (int k = 0; k < TOTAL; k++) begin
      if (rk_idx == 4'(k / 4)) rk_out[127-32*(k%4) -: 32] = r_file[k];
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule at NK = 4, 6 and 8 against a behavioural model.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         start4, start6, start8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [3:0]   rk_idx;
  logic         busy4, busy6, busy8, done4, done6, done8;
  logic         val4, val6, val8;
  logic [127:0] rk4, rk6, rk8;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] ref_w [60];

  always #5 clk = ~clk;

  aes_key_schedule #(.NK(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .key_in(key4), .busy(busy4), .done(done4),
    .rk_idx(rk_idx), .rk_out(rk4), .rk_valid(val4));
  aes_key_schedule #(.NK(6)) dut6 (
    .clk(clk), .reset(reset), .start(start6), .key_in(key6), .busy(busy6), .done(done6),
    .rk_idx(rk_idx), .rk_out(rk6), .rk_valid(val6));
  aes_key_schedule #(.NK(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .key_in(key8), .busy(busy8), .done(done8),
    .rk_idx(rk_idx), .rk_out(rk8), .rk_valid(val8));

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box via exp/log tables of generator 3.
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] x;
    logic [7:0] inv;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ xt(x);
    end
    for (int b = 0; b < 256; b++) begin
      inv = (b == 0) ? 8'h00 : ex[(255 - lg[b]) % 255];
      sbox_t[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // key is left-justified: word j is key[255-32*j -: 32].
  task automatic model_expand(input int nk, input logic [255:0] key);
    logic [7:0]  rc;
    logic [31:0] temp;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) ref_w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      temp = ref_w[i-1];
      if (i % nk == 0) begin
        temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        temp = subw(temp);
      end
      ref_w[i] = ref_w[i-nk] ^ temp;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int k);
    return {ref_w[4*k], ref_w[4*k+1], ref_w[4*k+2], ref_w[4*k+3]};
  endfunction

  // ---------------- DUT access ----------------
  function automatic logic [127:0] dut_rk(input int nk);
    case (nk)
      4: return rk4;
      6: return rk6;
      default: return rk8;
    endcase
  endfunction

  function automatic logic dut_valid(input int nk);
    case (nk)
      4: return val4;
      6: return val6;
      default: return val8;
    endcase
  endfunction

  function automatic logic dut_busy(input int nk);
    case (nk)
      4: return busy4;
      6: return busy6;
      default: return busy8;
    endcase
  endfunction

  function automatic logic dut_done(input int nk);
    case (nk)
      4: return done4;
      6: return done6;
      default: return done8;
    endcase
  endfunction

  // Pulse start for one edge (E0); returns 1 time unit after E0.
  task automatic kick(input int nk, input logic [255:0] key);
    key4 = key[255:128];
    key6 = key[255:64];
    key8 = key;
    case (nk)
      4: start4 = 1'b1;
      6: start6 = 1'b1;
      default: start8 = 1'b1;
    endcase
    @(posedge clk); #1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
  endtask

  // Edges after E0 until done is seen (200 on timeout).
  task automatic wait_done(input int nk, output int n);
    n = 0;
    while (!dut_done(nk) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int nks [3] = '{4, 6, 8};
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (dut_busy(nks[t]) !== 1'b0 || dut_done(nks[t]) !== 1'b0) begin
        errors++;
        $display("FAIL reset_status nk=%0d got busy=%b done=%b want 0 0", nks[t],
                 dut_busy(nks[t]), dut_done(nks[t]));
      end
      for (int k = 0; k < 3; k++) begin
        rk_idx = 4'(k * 5); #1;
        checks++;
        if (dut_valid(nks[t]) !== 1'b0 || dut_rk(nks[t]) !== 128'h0) begin
          errors++;
          $display("FAIL reset_rk nk=%0d idx=%0d got valid=%b rk=%h want 0 0", nks[t], k * 5,
                   dut_valid(nks[t]), dut_rk(nks[t]));
        end
      end
    end
  endtask

  task automatic test_known_answer();
    logic [255:0] keys [3];
    int           nks [3] = '{4, 6, 8};
    int           kat_nk [4] = '{4, 4, 6, 8};
    int           kat_idx [4] = '{1, 10, 12, 14};
    logic [127:0] kat_rk [4];
    int           n;
    keys[0] = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
    keys[1] = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b_0000000000000000;
    keys[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    kat_rk[0] = 128'ha0fafe1788542cb123a339392a6c7605;
    kat_rk[1] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    kat_rk[2] = 128'he98ba06f448c773c8ecc720401002202;
    kat_rk[3] = 128'hfe4890d1e6188d0b046df344706c631e;
    for (int t = 0; t < 3; t++) begin
      model_expand(nks[t], keys[t]);
      kick(nks[t], keys[t]);
      checks++;
      if (dut_busy(nks[t]) !== 1'b1) begin
        errors++;
        $display("FAIL busy_after_start nk=%0d got %b want 1", nks[t], dut_busy(nks[t]));
      end
      wait_done(nks[t], n);
      checks++;
      if (n != 4 * (nks[t] + 7) - nks[t] || dut_busy(nks[t]) !== 1'b0) begin
        errors++;
        $display("FAIL done_latency nk=%0d got edges=%0d busy=%b want edges=%0d busy=0", nks[t], n,
                 dut_busy(nks[t]), 4 * (nks[t] + 7) - nks[t]);
      end
      @(posedge clk); #1;
      checks++;
      if (dut_done(nks[t]) !== 1'b0) begin
        errors++;
        $display("FAIL done_single_cycle nk=%0d got %b want 0", nks[t], dut_done(nks[t]));
      end
      for (int r = 0; r < 4; r++) begin
        if (kat_nk[r] == nks[t]) begin
          rk_idx = 4'(kat_idx[r]); #1;
          checks++;
          if (dut_rk(nks[t]) !== kat_rk[r] || dut_valid(nks[t]) !== 1'b1) begin
            errors++;
            $display("FAIL kat nk=%0d idx=%0d got %h/%b want %h/1", nks[t], kat_idx[r],
                     dut_rk(nks[t]), dut_valid(nks[t]), kat_rk[r]);
          end
        end
      end
      for (int k = 0; k <= nks[t] + 6; k++) begin
        rk_idx = 4'(k); #1;
        checks++;
        if (dut_rk(nks[t]) !== exp_rk(k) || dut_valid(nks[t]) !== 1'b1) begin
          errors++;
          $display("FAIL model_round nk=%0d idx=%0d got %h/%b want %h/1", nks[t], k,
                   dut_rk(nks[t]), dut_valid(nks[t]), exp_rk(k));
        end
      end
      if (nks[t] == 8) begin
        rk_idx = 4'd15; #1;
        checks++;
        if (val8 !== 1'b0 || rk8 !== 128'h0) begin
          errors++;
          $display("FAIL out_of_range idx=15 got %h/%b want 0/0", rk8, val8);
        end
      end
    end
  endtask

  task automatic test_random();
    int           nks [3] = '{4, 6, 8};
    logic [255:0] key;
    int           n;
    for (int t = 0; t < 3; t++) begin
      repeat (2) begin
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        model_expand(nks[t], key);
        kick(nks[t], key);
        wait_done(nks[t], n);
        checks++;
        if (n != 4 * (nks[t] + 7) - nks[t]) begin
          errors++;
          $display("FAIL random_latency nk=%0d got %0d want %0d", nks[t], n,
                   4 * (nks[t] + 7) - nks[t]);
        end
        for (int k = 0; k <= nks[t] + 6; k++) begin
          rk_idx = 4'(k); #1;
          checks++;
          if (dut_rk(nks[t]) !== exp_rk(k)) begin
            errors++;
            $display("FAIL random_round nk=%0d idx=%0d got %h want %h", nks[t], k,
                     dut_rk(nks[t]), exp_rk(k));
          end
        end
      end
    end
  endtask

  // Round 2 needs word 11, written 8 edges after E0.
  task automatic test_early_read();
    logic [255:0] key;
    int           n;
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    model_expand(4, key);
    rk_idx = 4'd2;
    kick(4, key);
    for (int e = 0; e < 16; e++) begin
      checks++;
      if (val4 !== (e >= 8)) begin
        errors++;
        $display("FAIL early_valid edge=E0+%0d got %b want %b", e, val4, (e >= 8));
      end
      if (e >= 8) begin
        checks++;
        if (rk4 !== exp_rk(2)) begin
          errors++;
          $display("FAIL early_value edge=E0+%0d got %h want %h", e, rk4, exp_rk(2));
        end
      end
      @(posedge clk); #1;
    end
    wait_done(4, n);
    checks++;
    if (n != 24) begin
      errors++;
      $display("FAIL early_done got %0d more edges want 24", n);
    end
  endtask

  // start held high and key_in changed mid-run: no restart, one done.
  task automatic test_back_to_back();
    logic [255:0] key;
    int           dones;
    int           done_at;
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    model_expand(4, key);
    key4   = key[255:128];
    start4 = 1'b1;
    @(posedge clk); #1;
    dones   = 0;
    done_at = -1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (e == 10) key4 = {$urandom, $urandom, $urandom, $urandom};
      if (done4) begin
        dones++;
        done_at = e;
        start4 = 1'b0;
      end
    end
    start4 = 1'b0;
    checks++;
    if (dones != 1 || done_at != 40) begin
      errors++;
      $display("FAIL b2b_done got count=%0d at=%0d want count=1 at=40", dones, done_at);
    end
    for (int k = 0; k <= 10; k++) begin
      rk_idx = 4'(k); #1;
      checks++;
      if (rk4 !== exp_rk(k)) begin
        errors++;
        $display("FAIL b2b_round idx=%0d got %h want %h", k, rk4, exp_rk(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] key;
    int           n;
    key = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
    rk_idx = 4'd0;
    kick(4, key);
    repeat (19) begin
      @(posedge clk); #1;
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || val4 !== 1'b0 || rk4 !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b valid=%b rk=%h want 0 0 0 0", busy4, done4,
               val4, rk4);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    kick(4, key);
    wait_done(4, n);
    checks++;
    if (n != 40) begin
      errors++;
      $display("FAIL reset_restart_latency got %0d want 40", n);
    end
    rk_idx = 4'd10; #1;
    checks++;
    if (rk4 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL reset_restart_round10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk4);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4   = '0;   key6   = '0;   key8   = '0;
    rk_idx = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_known_answer();
    test_random();
    test_early_read();
    @(posedge clk); #1;
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
